// File: rtl/phase_sequencer.sv
// phase_sequencer
// Two-phase non-overlapping enable sequencer. Each machine cycle runs
// PH1 / gap / PH2 / gap. Each gap lasts GAP+1 clocks, so one machine cycle
// takes 2*GAP+4 clocks. Machine cycles run back to back while RUN is high
// and HALT_REQ is low. A rising edge on STEP requests exactly one cycle.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous reset, active low
//   RUN       in   free-run enable (level)
//   STEP      in   single-step request (rising edge)
//   HALT_REQ  in   stop at the end of the current machine cycle (level)
//   GAP[1:0]  in   dead-time setting, latched on each P1 entry
//   PH1, PH2  out  phase enables, decoded from the state register
//   SYNC      out  toggles once per completed machine cycle (resets to 1)
//   BUSY      out  high outside IDLE
//   HALTED    out  high in IDLE
//   CYC_CNT   out  completed machine cycle count, wraps at 255
//
// Build option: define CYCLE_COUNT_EN to build the cycle counter. If it is
// not defined, CYC_CNT is tied to 0 and no counter flops are built.
//
// state | meaning
// IDLE  | halted, waiting for RUN or a pending step
// P1    | phase-1 enable, one clock
// G1    | dead time between PH1 and PH2
// P2    | phase-2 enable, one clock
// G2    | dead time closing the machine cycle

module phase_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       HALT_REQ,
  input  logic [1:0] GAP,
  output logic       PH1,
  output logic       PH2,
  output logic       SYNC,
  output logic       BUSY,
  output logic       HALTED,
  output logic [7:0] CYC_CNT
);

  typedef enum logic [2:0] {IDLE, P1, G1, P2, G2} stateT;

  stateT      state;
  stateT      nextState;
  logic       armed;
  logic       stepDly;
  logic       stepPend;
  logic       stepEdge;
  logic       gapZero;
  logic       startReq;
  logic       cycleEnd;
  logic       enterP1;
  logic       enterGap;
  logic       syncReg;
  logic [1:0] gapLat;
  logic [1:0] gapCnt;

  assign stepEdge = STEP & ~stepDly;
  assign gapZero  = (gapCnt == 2'd0);
  // armed stays low for the first edge after reset release. This holds off
  // the first P1 until the second rising edge.
  assign startReq = armed & ((RUN & ~HALT_REQ) | stepPend);
  assign cycleEnd = (state == G2) & gapZero;
  // P1 is only ever entered from IDLE or G2, never held across cycles.
  assign enterP1  = (nextState == P1);
  assign enterGap = (state == P1) | (state == P2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startReq) nextState = P1;
      P1:      nextState = G1;
      G1:      if (gapZero) nextState = P2;
      P2:      nextState = G2;
      G2:      if (gapZero) nextState = startReq ? P1 : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    PH1    = (state == P1);
    PH2    = (state == P2);
    BUSY   = (state != IDLE);
    HALTED = (state == IDLE);
    SYNC   = syncReg;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      armed    <= 1'b0;
      stepDly  <= 1'b0;
      stepPend <= 1'b0;
      gapLat   <= 2'd0;
      gapCnt   <= 2'd0;
      syncReg  <= 1'b1;
    end else begin
      armed   <= 1'b1;
      stepDly <= STEP;
      // A P1 entry consumes the pending step. An edge arriving on that same
      // clock re-arms the flag. While the flag is set, further edges are
      // absorbed.
      if (enterP1) stepPend <= stepEdge;
      else         stepPend <= stepPend | stepEdge;
      if (enterP1) gapLat <= GAP;
      if (enterGap)
        gapCnt <= gapLat;
      else if (((state == G1) || (state == G2)) && !gapZero)
        gapCnt <= gapCnt - 2'd1;
      if (cycleEnd) syncReg <= ~syncReg;
    end
  end

`ifdef CYCLE_COUNT_EN
  logic [7:0] cycCnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)          cycCnt <= 8'd0;
    else if (cycleEnd) cycCnt <= cycCnt + 8'd1;
  end

  assign CYC_CNT = cycCnt;
`else
  assign CYC_CNT = 8'd0;
`endif

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named CLK and RST.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-low.
REQ-004 RUN  input  1  level; 1 = free-run machine cycles back to back.
REQ-005 STEP  input  1  single-step request; its rising edge (synchronous detect) requests exactly one machine cycle.
REQ-006 HALT_REQ  input  1  level; 1 = stop at the end of the current machine cycle.
REQ-007 GAP  input  2  dead-time setting; each gap lasts GAP+1 CLK cycles.
REQ-008 PH1  output  1  phase-1 enable, registered.
REQ-009 PH2  output  1  phase-2 enable, registered.
REQ-010 SYNC  output  1  toggles once per completed machine cycle.
REQ-011 BUSY  output  1  1 while in any state other than IDLE.
REQ-012 HALTED  output  1  1 while in IDLE.
REQ-013 CYC_CNT  output  8  count of completed machine cycles.

Function
REQ-014 The FSM SHALL have the states IDLE, P1, G1, P2 and G2; all outputs SHALL be decoded from registered state, with no combinational input-to-output paths.
REQ-015 PH1 SHALL be 1 only in P1, and PH2 SHALL be 1 only in P2; each phase lasts exactly 1 CLK cycle, and PH1 and PH2 SHALL never both be 1.
REQ-016 IDLE -> P1 SHALL occur when (RUN=1 and HALT_REQ=0) or a step is pending; PH1 goes high in the cycle after the edge that sampled the request.
REQ-017 P1 -> G1 and P2 -> G2 SHALL be unconditional; entering a gap loads a down-counter with the latched GAP value.
REQ-018 G1 -> P2 SHALL occur when the gap counter is 0, and the counter SHALL otherwise decrement; G2 SHALL use the same rule to end the machine cycle.
REQ-019 Machine cycle period SHALL be 2*GAP+4 CLK cycles; GAP=0 gives PH1 / gap / PH2 / gap in 4 cycles.
REQ-020 GAP SHALL be latched on every P1 entry; changes to GAP mid-cycle SHALL have no effect until the next P1.
REQ-021 At the end of G2: SYNC toggles, CYC_CNT increments, and the next state is P1 if RUN=1 and HALT_REQ=0, or if a step is pending; otherwise it is IDLE.
REQ-022 HALT_REQ SHALL never truncate a machine cycle, and it SHALL override RUN but not a pending step.
REQ-023 A STEP rising edge SHALL set a one-deep pending flag; edges arriving while the flag is already set SHALL be dropped.
REQ-024 The pending flag SHALL clear on P1 entry; if a new STEP edge coincides with P1 entry, the flag SHALL remain set.
REQ-025 CYC_CNT SHALL wrap from 255 to 0 without saturating.
REQ-026 When RUN and a step are active together, exactly one machine cycle SHALL run per P1 entry, and the step SHALL be consumed by that entry.

Reset
REQ-027 While RST=0: state IDLE, PH1=0, PH2=0, BUSY=0, HALTED=1, SYNC=1, CYC_CNT=0, step flag cleared, STEP edge-detect register=0, gap counter=0, latched GAP=0.
REQ-028 Reset asserted mid-cycle SHALL force PH1 and PH2 to 0 immediately (asynchronously), without completing the machine cycle.
REQ-029 After RST deasserts, the first P1 SHALL occur no earlier than the second rising edge of CLK.

Configuration
REQ-030 With CYCLE_COUNT_EN defined, CYC_CNT SHALL behave as REQ-021 and REQ-025 specify.
REQ-031 Without CYCLE_COUNT_EN, CYC_CNT SHALL be constant 0 and no counter flops SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-032 Reset release, GAP=0, RUN=1 -> PH1,0,PH2,0 repeating with period 4; SYNC toggles every 4 cycles; CYC_CNT=3 after 12 cycles.
REQ-033 GAP=3, RUN=1 -> period 10: PH1 for 1 cycle, 4 gap cycles, PH2 for 1 cycle, 4 gap cycles; GAP changed to 0 mid-cycle takes effect only at the next P1.
REQ-034 RUN=0, two STEP pulses 2 cycles apart while BUSY -> exactly 2 machine cycles, then HALTED=1 and CYC_CNT=2.
REQ-035 RUN=1, HALT_REQ asserted during G1 -> the cycle completes through G2, IDLE is entered, and no further PH1 appears; CYC_CNT+1 (counter built).
REQ-036 RST=0 asserted while PH2=1 -> PH2=0 with no clock edge, CYC_CNT=0, SYNC=1; with CYCLE_COUNT_EN undefined, 300 cycles of RUN leave CYC_CNT=0.
